repairclk_module: RTL and testbench

- Initiator-side MBINIT.REPAIRCLK sequencer; peer of the partner-side responder.
- Sends init_req, drives the clock-repair pattern window, then requests, latches and checks the partner's 3-bit clock-track result, and closes with done_req/done_resp.
- Sits between the MBINIT CAL stage, which enables it, and the REPAIRVAL stage, which it hands off to. It drives the shared sideband TX message bus.

---
 rtl/repairclk_pkg.sv | 34 +++
 rtl/repairclk_timer.sv | 36 +++
 rtl/repairclk_module.sv | 154 +++++++++++++++
 tb/tb_repairclk_module.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/repairclk_pkg.sv
// Shared definitions for the MBINIT.REPAIRCLK initiator sequencer.
package repairclk_pkg;

  // Sideband message encodings, shared with the partner-side responder.
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

  // Clock-track result bits {RCKP, RCKN, RTRK} that must all be set.
  localparam logic [2:0] PASS_MASK_DEFAULT = 3'b111;

  // Shared pattern/timeout counter width.
  localparam int unsigned TIMER_W = 24;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK_BUSY_INIT,
    ST_SEND_INIT,
    ST_WAIT_INIT,
    ST_PATTERN,
    ST_CHK_BUSY_RES,
    ST_SEND_RES,
    ST_WAIT_RES,
    ST_CHK_BUSY_DONE,
    ST_SEND_DONE,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/repairclk_timer.sv
// Loadable down-counter; tc flags a zero count while counting is enabled.
module repairclk_timer
  import repairclk_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == '0);

endmodule

// File: rtl/repairclk_module.sv
// MBINIT.REPAIRCLK initiator: init handshake, clock-repair pattern window,
// partner result check, done handshake.
module repairclk_module
  import repairclk_pkg::*;
#(
  parameter int unsigned PATTERN_CYCLES = 128,
  parameter int unsigned TIMEOUT_CYCLES = 8000000,
  parameter logic [2:0]  PASS_MASK      = PASS_MASK_DEFAULT
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_CAL_end,
  input  logic [3:0] i_RX_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_rx_result,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_pattern_en,
  output logic [2:0] o_clock_result,
  output logic       o_repairclk_end,
  output logic       o_train_error
);

  localparam logic [TIMER_W-1:0] PAT_LOAD = TIMER_W'(PATTERN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] msg_q, msg_d;
  logic       valid_q, valid_d;
  logic       pattern_q, pattern_d;
  logic [2:0] result_q, result_d;
  logic       end_q, end_d;
  logic       err_q, err_d;

  logic       rx_init_resp, rx_result_resp, rx_done_resp;
  logic       result_pass;
  logic       tmr_load, tmr_en, tmr_tc;
  logic [TIMER_W-1:0] tmr_load_val;

  assign rx_init_resp   = i_msg_valid && (i_RX_SbMessage == MSG_INIT_RESP);
  assign rx_result_resp = i_msg_valid && (i_RX_SbMessage == MSG_RESULT_RESP);
  assign rx_done_resp   = i_msg_valid && (i_RX_SbMessage == MSG_DONE_RESP);
  assign result_pass    = (i_rx_result & PASS_MASK) == PASS_MASK;

  // One counter serves both the pattern window and the response timeout;
  // it reloads on every state change.
  assign tmr_load = (state_d != state_q);
  assign tmr_en   = state_q inside {ST_PATTERN, ST_WAIT_INIT, ST_WAIT_RES, ST_WAIT_DONE};

  always_comb begin
    tmr_load_val = '0;
    if (state_d == ST_PATTERN) begin
      tmr_load_val = PAT_LOAD;
    end else if (state_d inside {ST_WAIT_INIT, ST_WAIT_RES, ST_WAIT_DONE}) begin
      tmr_load_val = TO_LOAD;
    end
  end

  repairclk_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // Abort takes priority; an expected message beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && !i_MBINIT_CAL_end) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:          if (i_MBINIT_CAL_end)    state_d = ST_CHK_BUSY_INIT;
        ST_CHK_BUSY_INIT: if (!i_Busy_SideBand)    state_d = ST_SEND_INIT;
        ST_SEND_INIT:     if (i_falling_edge_busy) state_d = ST_WAIT_INIT;
        ST_WAIT_INIT: begin
          if (rx_init_resp)  state_d = ST_PATTERN;
          else if (tmr_tc)   state_d = ST_ERROR;
        end
        ST_PATTERN:       if (tmr_tc)              state_d = ST_CHK_BUSY_RES;
        ST_CHK_BUSY_RES:  if (!i_Busy_SideBand)    state_d = ST_SEND_RES;
        ST_SEND_RES:      if (i_falling_edge_busy) state_d = ST_WAIT_RES;
        ST_WAIT_RES: begin
          if (rx_result_resp) state_d = result_pass ? ST_CHK_BUSY_DONE : ST_ERROR;
          else if (tmr_tc)    state_d = ST_ERROR;
        end
        ST_CHK_BUSY_DONE: if (!i_Busy_SideBand)    state_d = ST_SEND_DONE;
        ST_SEND_DONE:     if (i_falling_edge_busy) state_d = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (rx_done_resp)  state_d = ST_DONE;
          else if (tmr_tc)   state_d = ST_ERROR;
        end
        ST_DONE:          state_d = ST_DONE;
        ST_ERROR:         state_d = ST_ERROR;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    valid_d   = 1'b0;
    msg_d     = '0;
    pattern_d = (state_d == ST_PATTERN);
    end_d     = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERROR);
    unique case (state_d)
      ST_SEND_INIT: begin valid_d = 1'b1; msg_d = MSG_INIT_REQ;   end
      ST_SEND_RES:  begin valid_d = 1'b1; msg_d = MSG_RESULT_REQ; end
      ST_SEND_DONE: begin valid_d = 1'b1; msg_d = MSG_DONE_REQ;   end
      default: ;
    endcase
    result_d = result_q;
    if (state_d == ST_IDLE) begin
      result_d = '0;
    end else if ((state_q == ST_WAIT_RES) && rx_result_resp) begin
      result_d = i_rx_result;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      msg_q     <= '0;
      valid_q   <= 1'b0;
      pattern_q <= 1'b0;
      result_q  <= '0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      pattern_q <= pattern_d;
      result_q  <= result_d;
      end_q     <= end_d;
      err_q     <= err_d;
    end
  end

  assign o_TX_SbMessage         = msg_q;
  assign o_ValidOutDatat_Module = valid_q;
  assign o_pattern_en           = pattern_q;
  assign o_clock_result         = result_q;
  assign o_repairclk_end        = end_q;
  assign o_train_error          = err_q;

endmodule

// File: tb/tb_repairclk_module.sv
`timescale 1ns/1ps
module tb_repairclk_module;

  localparam int PAT = 8;
  localparam int TO  = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic [2:0] rx_result;
  logic       busy;
  logic       fe;

  logic [3:0] o_msg;
  logic       o_valid;
  logic       o_pat;
  logic [2:0] o_res;
  logic       o_end;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  repairclk_module #(
    .PATTERN_CYCLES (PAT),
    .TIMEOUT_CYCLES (TO),
    .PASS_MASK      (3'b111)
  ) dut (
    .CLK                    (clk),
    .rst_n                  (rst_n),
    .i_MBINIT_CAL_end       (en),
    .i_RX_SbMessage         (rx_msg),
    .i_msg_valid            (msg_valid),
    .i_rx_result            (rx_result),
    .i_Busy_SideBand        (busy),
    .i_falling_edge_busy    (fe),
    .o_TX_SbMessage         (o_msg),
    .o_ValidOutDatat_Module (o_valid),
    .o_pattern_en           (o_pat),
    .o_clock_result         (o_res),
    .o_repairclk_end        (o_end),
    .o_train_error          (o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: three request/response handshakes (index 0..2) with a
  // pattern window after the first; phase 0 = wait bus free, 1 = sending,
  // 2 = awaiting response. outcome 0 = running, 1 = passed, 2 = failed.
  bit         m_act   = 0;
  int         m_hs    = 0;
  int         m_phase = 0;
  bit         m_pat   = 0;
  int         m_patc  = 0;
  int         m_wait  = 0;
  int         m_out   = 0;
  logic [2:0] m_res   = '0;

  task automatic model_step();
    if (!rst_n) begin
      m_act = 0; m_hs = 0; m_phase = 0; m_pat = 0; m_patc = 0;
      m_wait = 0; m_out = 0; m_res = '0;
    end else if (!m_act) begin
      if (en) begin
        m_act = 1; m_hs = 0; m_phase = 0; m_pat = 0; m_out = 0;
      end
    end else if (!en) begin
      m_act = 0; m_hs = 0; m_phase = 0; m_pat = 0; m_out = 0; m_res = '0;
    end else if (m_out != 0) begin
      // terminal: hold
    end else if (m_pat) begin
      m_patc++;
      if (m_patc == PAT) begin
        m_pat = 0; m_hs = 1; m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (!busy) m_phase = 1;
    end else if (m_phase == 1) begin
      if (fe) begin m_phase = 2; m_wait = 0; end
    end else begin
      if (msg_valid && rx_msg == 4'(2 * m_hs + 2)) begin
        if (m_hs == 0) begin
          m_pat = 1; m_patc = 0;
        end else if (m_hs == 1) begin
          m_res = rx_result;
          if (rx_result == 3'b111) begin m_hs = 2; m_phase = 0; end
          else m_out = 2;
        end else begin
          m_out = 1;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) m_out = 2;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    bit ev;
    @(negedge clk);
    if (rst_n) begin
      ev = m_act && (m_out == 0) && !m_pat && (m_phase == 1);
      check("valid",   o_valid, ev);
      check("tx_msg",  o_msg,   ev ? 32'(2 * m_hs + 1) : 32'd0);
      check("pattern", o_pat,   m_act && m_pat);
      check("end",     o_end,   m_act && (m_out == 1));
      check("error",   o_err,   m_act && (m_out == 2));
      check("result",  o_res,   m_res);
    end
  end

  task automatic nxt();
    @(negedge clk);
    msg_valid = 1'b0;
    fe        = 1'b0;
    rx_msg    = '0;
  endtask

  task automatic send(input logic [3:0] m, input logic [2:0] r);
    msg_valid = 1'b1;
    rx_msg    = m;
    rx_result = r;
  endtask

  task automatic wait_valid(input logic [3:0] exp_msg, input string name);
    int n = 0;
    while (!o_valid && n < 40) begin
      nxt();
      n++;
    end
    check({name, "_valid"}, o_valid, 1);
    check({name, "_msg"},   o_msg,   exp_msg);
  endtask

  // Bus goes busy for two cycles, then the falling-edge pulse is driven.
  task automatic serve_tx();
    busy = 1'b1;
    nxt();
    nxt();
    busy = 1'b0;
    fe   = 1'b1;
  endtask

  task automatic pattern_len(output int cnt);
    int n = 0;
    cnt = 0;
    nxt();
    while (n < 40) begin
      if (o_pat) cnt++;
      else if (cnt > 0) break;
      nxt();
      n++;
    end
  endtask

  task automatic restart();
    en = 1'b0;
    nxt();
    nxt();
    en = 1'b1;
    nxt();
  endtask

  // Random environment state
  int         tx_cnt = 0;
  bit         tx_busy = 0;
  logic [3:0] tx_msg = '0;
  bit         rsp_pend = 0;
  int         rsp_dly = 0;
  logic [3:0] rsp_msg = '0;
  int         off_cnt = 0;
  int         n_done = 0, n_err = 0;

  task automatic env_step();
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy  = 0;
        fe       = 1'b1;
        rsp_pend = 1;
        rsp_msg  = tx_msg + 4'd1;
        rsp_dly  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(40, 60))
                                                : int'($urandom_range(0, 12));
      end
    end else if (o_valid && !tx_busy) begin
      tx_busy = 1;
      tx_cnt  = $urandom_range(1, 4);
      tx_msg  = o_msg;
    end
    if (!fe && $urandom_range(0, 63) == 0) fe = 1'b1;
    busy = tx_busy || ($urandom_range(0, 3) == 0);

    if (rsp_pend) begin
      if (rsp_dly == 0) begin
        msg_valid = 1'b1;
        rx_msg    = rsp_msg;
        rsp_pend  = 0;
      end else begin
        rsp_dly--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      rx_msg    = 4'($urandom_range(0, 15));
      msg_valid = 1'($urandom_range(0, 1));
    end
    rx_result = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;

    if (!en) begin
      if (off_cnt > 0) off_cnt--;
      else en = 1'b1;
    end else if (o_end || o_err) begin
      if ($urandom_range(0, 2) == 0) begin
        if (o_end) n_done++; else n_err++;
        en = 1'b0;
        off_cnt = $urandom_range(0, 3);
      end
    end else if ($urandom_range(0, 399) == 0) begin
      en = 1'b0;
      off_cnt = $urandom_range(0, 3);
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; en = 1'b0; rx_msg = '0; msg_valid = 1'b0;
    rx_result = '0; busy = 1'b0; fe = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_msg, o_valid, o_pat, o_res, o_end, o_err}, 0);
    rst_n = 1'b1;

    // Nominal pass
    en = 1'b1;
    nxt();
    wait_valid(4'd1, "nom_init");
    serve_tx(); nxt();
    send(4'd2, 3'b000);
    pattern_len(cnt);
    check("nom_pattern_len", cnt, PAT);
    wait_valid(4'd3, "nom_result_req");
    serve_tx(); nxt();
    send(4'd4, 3'b111);
    nxt();
    wait_valid(4'd5, "nom_done_req");
    serve_tx(); nxt();
    send(4'd6, 3'b000);
    nxt();
    check("nom_end",    o_end, 1);
    check("nom_result", o_res, 3'b111);
    check("nom_error",  o_err, 0);

    // Failing clock-track result
    restart();
    wait_valid(4'd1, "fail_init");
    serve_tx(); nxt();
    send(4'd2, 3'b000);
    pattern_len(cnt);
    wait_valid(4'd3, "fail_result_req");
    serve_tx(); nxt();
    send(4'd4, 3'b101);
    nxt();
    check("fail_error",  o_err, 1);
    check("fail_result", o_res, 3'b101);
    cnt = 0;
    repeat (10) begin nxt(); if (o_valid) cnt++; end
    check("fail_no_done_req", cnt, 0);

    // Busy gating
    en = 1'b0; busy = 1'b1;
    nxt(); nxt();
    en = 1'b1;
    cnt = 0;
    repeat (20) begin nxt(); if (o_valid) cnt++; end
    check("busy_gated_valid", cnt, 0);
    busy = 1'b0;
    nxt();
    check("busy_release_valid", o_valid, 1);
    check("busy_release_msg",   o_msg,   4'd1);

    // Timeout in WAIT_INIT
    serve_tx();
    repeat (TO) nxt();
    check("timeout_not_yet", o_err, 0);
    nxt();
    check("timeout_error", o_err, 1);

    // init_resp on the last wait cycle beats the timeout
    restart();
    wait_valid(4'd1, "edge_init");
    serve_tx();
    repeat (TO) nxt();
    send(4'd2, 3'b000);
    nxt();
    check("edge_pattern", o_pat, 1);
    check("edge_error",   o_err, 0);

    // Abort mid-pattern
    repeat (3) nxt();
    en = 1'b0;
    nxt();
    check("abort_outputs", {o_msg, o_valid, o_pat, o_res, o_end, o_err}, 0);
    en = 1'b1;
    nxt();
    wait_valid(4'd1, "abort_restart");

    // Noise while waiting for init_resp
    serve_tx(); nxt();
    send(4'd6, 3'b000); nxt();
    send(4'd4, 3'b111); nxt();
    rx_msg = 4'd2; nxt();
    check("noise_quiet", {o_valid, o_pat, o_end, o_err, o_res}, 0);
    send(4'd2, 3'b000);
    nxt();
    check("noise_then_pattern", o_pat, 1);

    // Randomised traffic
    en = 1'b0; busy = 1'b0;
    nxt(); nxt();
    repeat (20000) begin
      nxt();
      env_step();
    end
    $display("Random phase: %0d passes, %0d failures/timeouts observed", n_done, n_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
